// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between a CPU port and
// a loader/debug port.
//
// Each access goes IDLE -> ACCESS, or IDLE -> ACCESS -> RESP for a read. A
// request seen in IDLE is latched at the clock edge. The grant pulse is
// issued in ACCESS, and read data is returned in RESP.
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   - ties are resolved round-robin, favouring the requester that
//               was not granted last.
//   undefined - fixed priority; the CPU wins every tie.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cpu_req/we/addr/wdata            CPU request, held until cpu_gnt
//   cpu_gnt, cpu_rvalid              CPU grant pulse, CPU read-return pulse
//   ldr_req/we/addr/wdata            loader request, held until ldr_gnt
//   ldr_gnt, ldr_rvalid              loader grant pulse, loader read-return pulse
//   rdata                            shared read data, nonzero only in RESP
//   ram_read_en/write_en/addr/wdata  RAM command port
//   ram_rdata                        RAM read data, one cycle after ram_read_en
//   busy                             high whenever the FSM is not in IDLE
module mem_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_read_en,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Latched winner and its access, captured when leaving IDLE.
    logic              win_ldr;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    logic              tie_ldr;
    logic              pick_ldr;

`ifdef MEM_ARB_RR_EN
    // Remembers who was granted last. It resets to "loader" so that the CPU
    // wins the first tie.
    logic last_ldr;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_ldr <= 1'b1;
        end else if (state == ACCESS) begin
            last_ldr <= win_ldr;
        end
    end

    assign tie_ldr = ~last_ldr;
`else
    assign tie_ldr = 1'b0;
`endif

    // Winner selection: a lone requester wins; ties go to tie_ldr.
    always_comb begin
        pick_ldr = 1'b0;
        if (ldr_req && !cpu_req) begin
            pick_ldr = 1'b1;
        end else if (ldr_req && cpu_req) begin
            pick_ldr = tie_ldr;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the winning access on the IDLE -> ACCESS transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_ldr   <= 1'b0;
            acc_we    <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
        end else if (state == IDLE && (cpu_req || ldr_req)) begin
            win_ldr   <= pick_ldr;
            acc_we    <= pick_ldr ? ldr_we    : cpu_we;
            acc_addr  <= pick_ldr ? ldr_addr  : cpu_addr;
            acc_wdata <= pick_ldr ? ldr_wdata : cpu_wdata;
        end
    end

    // Next-state and output decode. Reset blanks every output in the same
    // cycle, so an access that is in flight when reset arrives is dropped.
    always_comb begin
        state_next   = state;
        cpu_gnt      = 1'b0;
        ldr_gnt      = 1'b0;
        cpu_rvalid   = 1'b0;
        ldr_rvalid   = 1'b0;
        rdata        = '0;
        ram_read_en  = 1'b0;
        ram_write_en = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        busy         = 1'b0;

        case (state)
            IDLE: begin
                if (cpu_req || ldr_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                busy         = 1'b1;
                ram_addr     = acc_addr;
                ram_wdata    = acc_wdata;
                ram_write_en = acc_we;
                ram_read_en  = ~acc_we;
                cpu_gnt      = ~win_ldr;
                ldr_gnt      = win_ldr;
                state_next   = acc_we ? IDLE : RESP;
            end
            RESP: begin
                busy       = 1'b1;
                rdata      = ram_rdata;
                cpu_rvalid = ~win_ldr;
                ldr_rvalid = win_ldr;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (reset) begin
            cpu_gnt      = 1'b0;
            ldr_gnt      = 1'b0;
            cpu_rvalid   = 1'b0;
            ldr_rvalid   = 1'b0;
            rdata        = '0;
            ram_read_en  = 1'b0;
            ram_write_en = 1'b0;
            ram_addr     = '0;
            ram_wdata    = '0;
            busy         = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter, with a behavioural synchronous RAM.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    // Expected-output vectors, ordered as
    // {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, ram_read_en, ram_write_en, busy}
    localparam logic [6:0] V_IDLE   = 7'b0000000;
    localparam logic [6:0] V_CPU_RD = 7'b1000101;
    localparam logic [6:0] V_CPU_WR = 7'b1000011;
    localparam logic [6:0] V_CPU_RV = 7'b0010001;
    localparam logic [6:0] V_LDR_RD = 7'b0100101;
    localparam logic [6:0] V_LDR_WR = 7'b0100011;
    localparam logic [6:0] V_LDR_RV = 7'b0001001;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_rvalid;
    logic              ldr_req, ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt, ldr_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              ram_read_en, ram_write_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;

    logic [DATA_W-1:0] mem [32];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .cpu_rvalid   (cpu_rvalid),
        .ldr_req      (ldr_req),
        .ldr_we       (ldr_we),
        .ldr_addr     (ldr_addr),
        .ldr_wdata    (ldr_wdata),
        .ldr_gnt      (ldr_gnt),
        .ldr_rvalid   (ldr_rvalid),
        .rdata        (rdata),
        .ram_read_en  (ram_read_en),
        .ram_write_en (ram_write_en),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .busy         (busy)
    );

    // Synchronous RAM: read data appears one cycle after ram_read_en.
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_addr] <= ram_wdata;
        if (ram_read_en)  ram_rdata     <= mem[ram_addr];
    end

    function automatic logic [6:0] vec();
        return {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, ram_read_en, ram_write_en, busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [6:0] exp_v;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[5]    = 8'hA3;
        ram_rdata = '0;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("reset_vec",   32'(vec()), 32'(V_IDLE));
        chk("reset_addr",  32'(ram_addr), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_vec", 32'(vec()), 32'(V_IDLE));

        // CPU read of address 5.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
        @(negedge clk);
        chk("cpu_rd_gnt",  32'(vec()), 32'(V_CPU_RD));
        chk("cpu_rd_addr", 32'(ram_addr), 32'd5);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("cpu_rd_rv",    32'(vec()), 32'(V_CPU_RV));
        chk("cpu_rd_rdata", 32'(rdata), 32'hA3);
        @(negedge clk);
        chk("cpu_rd_done", 32'(vec()), 32'(V_IDLE));

        // Loader write 8'h5C to address 31.
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 5'd31; ldr_wdata = 8'h5C;
        @(negedge clk);
        chk("ldr_wr_gnt",   32'(vec()), 32'(V_LDR_WR));
        chk("ldr_wr_addr",  32'(ram_addr), 32'd31);
        chk("ldr_wr_wdata", 32'(ram_wdata), 32'h5C);
        ldr_req = 1'b0;
        @(negedge clk);
        chk("ldr_wr_idle", 32'(vec()), 32'(V_IDLE));

        // CPU read-back of address 31.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd31;
        @(negedge clk);
        chk("rb_gnt", 32'(vec()), 32'(V_CPU_RD));
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rb_rdata", 32'(rdata), 32'h5C);
        @(negedge clk);

        // Both requesters hold writes for four grants, starting from a fresh reset.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd1; cpu_wdata = 8'h11;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 5'd2; ldr_wdata = 8'h22;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef MEM_ARB_RR_EN
            exp_v = (i % 2 == 0) ? V_CPU_WR : V_LDR_WR;
`else
            exp_v = V_CPU_WR;
`endif
            chk($sformatf("tie_gnt%0d", i), 32'(vec()), 32'(exp_v));
            @(negedge clk);
            chk($sformatf("tie_idle%0d", i), 32'(vec()), 32'(V_IDLE));
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        @(negedge clk);
        chk("tie_quiet", 32'(vec()), 32'(V_IDLE));

        // Loader request arrives during a CPU RESP cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
        @(negedge clk);
        chk("late_cpu_gnt", 32'(vec()), 32'(V_CPU_RD));
        cpu_req = 1'b0;
        @(negedge clk);
        chk("late_cpu_rv", 32'(vec()), 32'(V_CPU_RV));
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 5'd31;
        @(negedge clk);
        chk("late_idle", 32'(vec()), 32'(V_IDLE));
        @(negedge clk);
        chk("late_ldr_gnt",  32'(vec()), 32'(V_LDR_RD));
        chk("late_ldr_addr", 32'(ram_addr), 32'd31);
        ldr_req = 1'b0;
        @(negedge clk);
        chk("late_ldr_rv",    32'(vec()), 32'(V_LDR_RV));
        chk("late_ldr_rdata", 32'(rdata), 32'h5C);
        @(negedge clk);

        // Reset arrives in the middle of an ACCESS write.
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 5'd3; ldr_wdata = 8'h77;
        @(negedge clk);
        chk("rst_acc_wr", 32'(vec()), 32'(V_LDR_WR));
        reset = 1'b1; ldr_req = 1'b0;
        #1;
        chk("rst_force_vec",  32'(vec()), 32'(V_IDLE));
        chk("rst_force_addr", 32'(ram_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_after", 32'(vec()), 32'(V_IDLE));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_quiet%0d", i), 32'(vec()), 32'(V_IDLE));
        end

        // The aborted write must not have reached the RAM.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd3;
        @(negedge clk);
        chk("rst_rb_gnt", 32'(vec()), 32'(V_CPU_RD));
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rst_rb_rdata", 32'(rdata), 32'h00);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
